// File: rtl/demux4_router.sv
// demux4_router
//   Registered 1-to-4 demultiplexer. Each accepted input word goes into the
//   single-entry holding register of the selected channel, or into all four
//   channels when broadcast_i is set. Each holding register has its own
//   valid/ready output handshake.
//
// Ports
//   clk_i                 system clock, rising edge
//   reset_ni              asynchronous active-low reset
//   valid_i / ready_o     input stream handshake (ready_o is combinational)
//   select_i              destination channel 0..3, used only when a word is accepted
//   broadcast_i           write the word to all four channels; select_i is ignored
//   data_i                input word
//   dataK_o / validK_o    holding register contents and occupancy of channel K
//   readyK_i              consumer K takes the word this cycle
module demux4_router #(
  parameter int DATA_WIDTH  = 16,
  parameter int SELECT_SIZE = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [SELECT_SIZE-1:0] select_i,
  input  logic                   broadcast_i,
  input  logic [DATA_WIDTH-1:0]  data_i,
  output logic [DATA_WIDTH-1:0]  data0_o,
  output logic [DATA_WIDTH-1:0]  data1_o,
  output logic [DATA_WIDTH-1:0]  data2_o,
  output logic [DATA_WIDTH-1:0]  data3_o,
  output logic                   valid0_o,
  output logic                   valid1_o,
  output logic                   valid2_o,
  output logic                   valid3_o,
  input  logic                   ready0_i,
  input  logic                   ready1_i,
  input  logic                   ready2_i,
  input  logic                   ready3_i
);

  logic                  slot_vld  [4];
  logic [DATA_WIDTH-1:0] slot_data [4];

  logic [3:0] rdy;
  logic [3:0] vld;
  logic [3:0] free;
  logic [3:0] drain;
  logic [3:0] load;
  logic       acc;

  assign rdy = {ready3_i, ready2_i, ready1_i, ready0_i};
  assign vld = {slot_vld[3], slot_vld[2], slot_vld[1], slot_vld[0]};

  // A slot can take a new word if it is empty or its current word leaves
  // this same cycle, which gives one word per cycle per channel.
  assign free  = ~vld | rdy;
  assign drain = vld & rdy;

  // Broadcast is all-or-nothing, so it needs every slot free at once.
  // ready_o deliberately ignores valid_i so that it never depends on it.
  always_comb begin
    ready_o = 1'b0;
    if (broadcast_i) ready_o = &free;
    else             ready_o = free[select_i];
  end

  assign acc = valid_i & ready_o;

  always_comb begin
    load = 4'b0000;
    if (acc) begin
      if (broadcast_i) load = 4'b1111;
      else             load = 4'b0001 << select_i;
    end
  end

  // Each slot is an independent EMPTY/FULL holding register. A load takes
  // priority over a drain in the same cycle; data changes only on a load.
  for (genvar k = 0; k < 4; k++) begin : g_slot
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        slot_vld[k]  <= 1'b0;
        slot_data[k] <= '0;
      end else if (load[k]) begin
        slot_vld[k]  <= 1'b1;
        slot_data[k] <= data_i;
      end else if (drain[k]) begin
        slot_vld[k]  <= 1'b0;
      end
    end
  end

  assign data0_o  = slot_data[0];
  assign data1_o  = slot_data[1];
  assign data2_o  = slot_data[2];
  assign data3_o  = slot_data[3];
  assign valid0_o = slot_vld[0];
  assign valid1_o = slot_vld[1];
  assign valid2_o = slot_vld[2];
  assign valid3_o = slot_vld[3];

endmodule

// File: doc/demux4_router.md
Name: demux4_router

Overview:
- Registered 1-to-4 demultiplexer: the distribution counterpart to the Mux2/Mux4/Mux8 selectors.
- Accepts one valid/ready input stream with a destination select and routes each word into one of four single-entry output holding registers. Each register drives its own valid/ready output channel.
- Optional broadcast mode writes the same word to all four channels at once.
- Used between the datapath bus and multiple consumers, e.g. register-file write ports and the memory write buffer.

Parameters:
- DATA_WIDTH, 16, width of the data word.
- SELECT_SIZE, 2, width of select_i; fixed at 2 for four outputs.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- reset_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input word present.
- ready_o  output  1  router can accept the input word this cycle.
- select_i  input  SELECT_SIZE  destination channel 0..3; sampled only on accept.
- broadcast_i  input  1  when 1, the word goes to all four channels and select_i is ignored.
- data_i  input  DATA_WIDTH  input word.
- data0_o..data3_o  output  DATA_WIDTH each  channel holding-register contents.
- valid0_o..valid3_o  output  1 each  channel k holds an undelivered word.
- ready0_i..ready3_i  input  1 each  consumer k takes the word this cycle.

Behaviour:
- Reset, asynchronous on reset_ni low: all validk_o=0 and all datak_o=0. Reset asserted mid-transfer discards any buffered words; no partial state survives. ready_o is combinational and reads 1 while in reset.
- Drain condition: drain_k = validk_o & readyk_i.
- free_k = ~validk_o | readyk_i. A slot is writable if it is empty or is being drained in the same cycle.
- ready_o when broadcast_i=0: free_k for k=select_i.
- ready_o when broadcast_i=1: free_0 & free_1 & free_2 & free_3.
- ready_o is combinational from select_i, broadcast_i, validk_o and readyk_i. It does not depend on valid_i.
- Accept: acc = valid_i & ready_o.
- Load: load_k = acc & (broadcast_i | select_i==k).
- Slot update, per edge:
  - load_k: datak_o<=data_i and validk_o<=1. Load wins over a simultaneous drain, so back-to-back throughput is 1 word/cycle per channel.
  - else if drain_k: validk_o<=0 and datak_o holds its value.
  - else: hold.
- Latency: a word accepted on edge N appears on its channel's outputs after edge N, i.e. one cycle.
- Ordering: words to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Blocking: a full, undrained target slot stalls the input (ready_o=0). Other slots keep draining independently; there is no head-of-line effect on their outputs.
- Broadcast: all-or-nothing. No channel is written unless every channel is free in that cycle.
- Value stability: datak_o changes only on load_k, never on drain. valid_i=0 never modifies any slot.
- Inputs with X on select_i while valid_i=0 are don't-care.
- No internal FSM beyond the four independent valid bits. Each slot is a two-state EMPTY/FULL machine:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on load with drain, or on no drain.

Test Plan:
1. Reset, then valid_i=1, select_i=2, data_i=16'hA5A5 for one cycle with all readyk_i=0 -> next cycle valid2_o=1, data2_o=A5A5, other valids 0. ready_o=0 for select_i=2, 1 for select_i=0.
2. Channel 1 full, ready1_i=0, present 16'h1234 to select_i=1 -> ready_o=0 and slot unchanged. Raise ready1_i=1 -> same cycle ready_o=1; next cycle data1_o=1234 and valid1_o stays 1.
3. Stream 16'h0001..16'h0008 to channel 3 with ready3_i held 1 -> accepted one per cycle, and data3_o shows 1..8 on consecutive cycles with valid3_o continuously 1.
4. broadcast_i=1, data_i=16'hBEEF, channel 0 full with ready0_i=0 -> ready_o=0 and no channel written. Release ready0_i -> all four datak_o=BEEF and validk_o=1 next cycle.
5. Load channels 0 and 3, then drop reset_ni mid-cycle -> all valids and datas read 0 immediately, without waiting for a clock edge. After release, the first accept behaves as in scenario 1.
6. Drain-only: channel 2 holds 16'h5555 and ready2_i=1 with valid_i=0 -> valid2_o=0 next cycle and data2_o remains 5555.
